// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst-locking write arbiter in front of a single FIFO write port.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   k;
  logic          own_req;
  logic          accept;
  logic          last;

  // First requester at or above rr_q, wrapping explicitly at NREQ-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = {1'b0, rr_q} + (IW+1)'(i);
      if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
      if (!found && req[k[IW-1:0]]) begin
        found = 1'b1;
        pick  = k[IW-1:0];
      end
    end
  end

  assign own_req    = req[owner_q];
  assign busy       = (state_q == BURST);
  assign accept     = busy && own_req && !fifo_full;
  assign last       = (cnt_q == CW'(MAX_BURST - 1));
  assign fifo_wr_en = accept;
  assign gnt        = accept ? (NREQ'(1) << owner_q) : '0;
  assign fifo_din   = din[owner_q*WIDTH +: WIDTH];
  assign owner      = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if ((accept && last) || !own_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (busy && own_req && fifo_full
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
